// File: rtl/font_writer8x8_pkg.sv
// Shared constants, state encoding and address helper for the 8x8 glyph store.
package font_writer8x8_pkg;

    localparam int unsigned GLYPH_COLS    = 8;
    localparam int unsigned GLYPH_ROWS    = 8;
    localparam int unsigned GLYPH_CHARS   = 256;
    localparam int unsigned GLYPH_ENTRIES = 16384;
    localparam int unsigned ALPHA_W       = 3;

    localparam int unsigned CHAR_W = $clog2(GLYPH_CHARS);
    localparam int unsigned ROW_W  = $clog2(GLYPH_ROWS);
    localparam int unsigned COL_W  = $clog2(GLYPH_COLS);
    localparam int unsigned ADDR_W = $clog2(GLYPH_ENTRIES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW   = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Glyph RAM address layout: {char, row, column}.
    function automatic logic [ADDR_W-1:0] glyph_addr(
        input logic [CHAR_W-1:0] ch,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col
    );
        return {ch, row, col};
    endfunction

endpackage

// File: rtl/font_writer8x8.sv
// font_writer8x8: serialises host glyph-row writes (and a bulk clear) onto the
// single-entry write port of the 8x8 glyph store.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_valid / o_ready       : row-write / clear handshake
//   i_char, i_row, i_data   : row payload, column c alpha in i_data[3c+2:3c]
//   i_clear                 : bulk clear request, wins over i_valid
//   i_mono                  : (FONT_WRITER_MONO_EN only) 1 bit/pixel row in i_data[7:0]
//   o_we, o_addr, o_wdata   : glyph RAM write port
//   o_busy, o_done          : operation in progress / one-cycle completion pulse
// Optional feature macro: FONT_WRITER_MONO_EN.
module font_writer8x8
    import font_writer8x8_pkg::*;
#(
    parameter int unsigned       ALPHA_W     = font_writer8x8_pkg::ALPHA_W,
    parameter logic [ALPHA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [CHAR_W-1:0]             i_char,
    input  logic [ROW_W-1:0]              i_row,
    input  logic [GLYPH_COLS*ALPHA_W-1:0] i_data,
    input  logic                          i_clear,
`ifdef FONT_WRITER_MONO_EN
    input  logic                          i_mono,
`endif
    output logic                          o_we,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [ALPHA_W-1:0]            o_wdata,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int unsigned DATA_W = GLYPH_COLS * ALPHA_W;
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(GLYPH_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GLYPH_ENTRIES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [DATA_W-1:0]   data_q, data_d;
`ifdef FONT_WRITER_MONO_EN
    logic                mono_q, mono_d;
`endif

    logic                we_d, ready_d, busy_d, done_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [ALPHA_W-1:0]  wdata_d;
    logic [COL_W-1:0]    col;

    // State, counter and latched row payload.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            char_q  <= '0;
            row_q   <= '0;
            data_q  <= '0;
`ifdef FONT_WRITER_MONO_EN
            mono_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            row_q   <= row_d;
            data_q  <= data_d;
`ifdef FONT_WRITER_MONO_EN
            mono_q  <= mono_d;
`endif
        end
    end

    // Next state; the counter low bits double as the column index in ROW.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        row_d   = row_q;
        data_d  = data_q;
`ifdef FONT_WRITER_MONO_EN
        mono_d  = mono_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (i_valid) begin
                    state_d = ROW;
                    cnt_d   = '0;
                    char_d  = i_char;
                    row_d   = i_row;
                    data_d  = i_data;
`ifdef FONT_WRITER_MONO_EN
                    mono_d  = i_mono;
`endif
                end
            end
            ROW: begin
                if (cnt_q[COL_W-1:0] == LAST_COL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        col     = cnt_d[COL_W-1:0];
        we_d    = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q != IDLE) && (state_d == IDLE);
        addr_d  = '0;
        wdata_d = '0;
        unique case (state_d)
            ROW: begin
                addr_d  = glyph_addr(char_d, row_d, col);
                wdata_d = data_d[int'(col)*ALPHA_W +: ALPHA_W];
`ifdef FONT_WRITER_MONO_EN
                // Mono rows: MSB of i_data[7:0] is the leftmost column.
                if (mono_d) begin
                    wdata_d = {ALPHA_W{data_d[LAST_COL - col]}};
                end
`endif
            end
            CLEAR: begin
                addr_d  = cnt_d;
                wdata_d = CLEAR_VALUE;
            end
            default: begin
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready <= 1'b1;
            o_we    <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_ready <= ready_d;
            o_we    <= we_d;
            o_addr  <= addr_d;
            o_wdata <= wdata_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_font_writer8x8.sv
// Scoreboard bench for font_writer8x8: the stimulus side predicts every glyph
// RAM write and completion pulse (with its cycle) from the row/clear rules;
// a monitor pops and compares whatever the DUT presents.
module tb_font_writer8x8;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_char;
    logic [2:0]  i_row;
    logic [23:0] i_data;
    logic        i_clear;
`ifdef FONT_WRITER_MONO_EN
    logic        i_mono;
`endif
    logic        o_we;
    logic [13:0] o_addr;
    logic [2:0]  o_wdata;
    logic        o_busy;
    logic        o_done;

    font_writer8x8 dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_char  (i_char),
        .i_row   (i_row),
        .i_data  (i_data),
        .i_clear (i_clear),
`ifdef FONT_WRITER_MONO_EN
        .i_mono  (i_mono),
`endif
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_wdata (o_wdata),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t     q[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    logic [2:0] ref_mem [16384];
    logic [2:0] dut_mem [16384];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every presented write / done must match the head of the queue.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (i_rst_n === 1'b1) begin
            check("busy_is_not_ready", 32'(o_busy), 32'(!o_ready));
            if (o_we === 1'b1) begin
                dut_mem[o_addr] = o_wdata;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data %0d at cycle %0d, none expected",
                             o_addr, o_wdata, cyc);
                end else begin
                    e = q.pop_front();
                    check("write_kind", 32'(0), 32'(e.is_done));
                    check("write_addr", 32'(o_addr), e.addr);
                    check("write_data", 32'(o_wdata), e.data);
                    check("write_cycle", cyc, e.cyc);
                    check("ready_low_during_write", 32'(o_ready), 0);
                end
            end
            if (o_done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: o_done=1 at cycle %0d, none expected", cyc);
                end else begin
                    e = q.pop_front();
                    check("done_kind", 32'(1), 32'(e.is_done));
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    // Reference: row write of ncols columns starting at cycle a.
    task automatic push_row(input int ch, input int row, input int data, input bit mono,
                            input int a, input int ncols, input bit with_done);
        int addr;
        int alpha;
        for (int c = 0; c < ncols; c++) begin
            if (mono) alpha = ((data >> (7 - c)) & 1) != 0 ? 7 : 0;
            else      alpha = (data >> (3 * c)) & 7;
            addr = ch * 64 + row * 8 + c;
            q.push_back('{is_done: 1'b0, addr: addr, data: alpha, cyc: a + c});
            ref_mem[addr] = 3'(alpha);
        end
        if (with_done) q.push_back('{is_done: 1'b1, addr: 0, data: 0, cyc: a + 8});
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: o_ready stayed %b for %0d cycles", o_ready, budget);
        end
    endtask

    // Offer a row, wait for acceptance; returns the cycle of its first write.
    task automatic send_row(input int ch, input int row, input int data, input bit mono,
                            output int a);
        bit ok;
        i_valid = 1'b1;
        i_clear = 1'b0;
        i_char  = 8'(ch);
        i_row   = 3'(row);
        i_data  = 24'(data);
`ifdef FONT_WRITER_MONO_EN
        i_mono  = mono;
`endif
        wait_ready(200, ok);
        a = cyc + 1;
        if (ok) push_row(ch, row, data, mono, a, 8, 1'b1);
        tick();
    endtask

    task automatic send_clear(input bit with_valid);
        bit ok;
        int a;
        i_clear = 1'b1;
        i_valid = with_valid;
        i_char  = 8'($urandom);
        i_row   = 3'($urandom);
        i_data  = 24'($urandom);
        wait_ready(200, ok);
        a = cyc + 1;
        if (ok) begin
            for (int k = 0; k < 16384; k++) begin
                q.push_back('{is_done: 1'b0, addr: k, data: 0, cyc: a + k});
                ref_mem[k] = 3'd0;
            end
            q.push_back('{is_done: 1'b1, addr: 0, data: 0, cyc: a + 16384});
        end
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && o_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected items still pending after %0d cycles",
                     q.size(), budget);
        end
        tick();
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a1, a2, a, mism;
        bit ok;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_char  = '0;
        i_row   = '0;
        i_data  = '0;
`ifdef FONT_WRITER_MONO_EN
        i_mono  = 1'b0;
`endif
        for (int k = 0; k < 16384; k++) begin
            ref_mem[k] = 3'd0;
            dut_mem[k] = 3'd0;
        end
        repeat (3) tick();
        check("reset_ready", 32'(o_ready), 1);
        check("reset_we",    32'(o_we),    0);
        check("reset_addr",  32'(o_addr),  0);
        check("reset_wdata", 32'(o_wdata), 0);
        check("reset_busy",  32'(o_busy),  0);
        check("reset_done",  32'(o_done),  0);
        i_rst_n = 1'b1;
        tick();

        // Directed row: columns carry alphas 0..7.
        send_row(8'h41, 3, 24'hFAC688, 1'b0, a1);
        i_valid = 1'b0;
        drain(50);
        for (int c = 0; c < 8; c++) check("directed_col_alpha", 32'(dut_mem[8'h41 * 64 + 3 * 8 + c]), c);

        // Clear has priority over a simultaneous row offer.
        send_clear(1'b1);
        drain(20000);

        // Random rows with random idle gaps.
        repeat (20) begin
            send_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                     int'($urandom & 32'hFFFFFF), 1'b0, a);
            i_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        drain(100);

        // Back-to-back: valid held, second accept lands in the done cycle.
        send_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                 int'($urandom & 32'hFFFFFF), 1'b0, a1);
        send_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                 int'($urandom & 32'hFFFFFF), 1'b0, a2);
        i_valid = 1'b0;
        check("back_to_back_spacing", a2 - a1, 9);
        drain(50);

        // i_valid and payload toggling while busy must be ignored.
        send_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                 int'($urandom & 32'hFFFFFF), 1'b0, a);
        repeat (7) begin
            i_valid = 1'($urandom);
            i_char  = 8'($urandom);
            i_row   = 3'($urandom);
            i_data  = 24'($urandom);
            tick();
        end
        i_valid = 1'b0;
        drain(50);

        // Reset after the third write of a row: remainder abandoned, no done.
        i_valid = 1'b1;
        i_clear = 1'b0;
        i_char  = 8'h5A;
        i_row   = 3'd6;
        i_data  = 24'($urandom);
        wait_ready(50, ok);
        push_row(8'h5A, 6, int'(i_data), 1'b0, cyc + 1, 3, 1'b0);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b0;
        #1;
        check("reset_mid_row_we",   32'(o_we),   0);
        check("reset_mid_row_done", 32'(o_done), 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(o_ready), 1);
        repeat (12) tick();
        check("abandoned_row_queue", q.size(), 0);

`ifdef FONT_WRITER_MONO_EN
        // Mono row: only the two edge pixels set.
        send_row(8'h7E, 2, 24'hABCD81, 1'b1, a);
        i_valid = 1'b0;
        drain(50);
        for (int c = 0; c < 8; c++)
            check("mono_col_alpha", 32'(dut_mem[8'h7E * 64 + 2 * 8 + c]), (c == 0 || c == 7) ? 7 : 0);
        repeat (6) begin
            send_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                     int'($urandom & 32'hFFFFFF), 1'($urandom), a);
            i_valid = 1'b0;
        end
        drain(100);
`endif

        mism = 0;
        for (int k = 0; k < 16384; k++) if (dut_mem[k] !== ref_mem[k]) mism++;
        check("glyph_ram_image_mismatches", mism, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
